gemm_tile_scheduler: RTL and testbench
======================================

Name: gemm_tile_scheduler

Overview:
Sequences one GEMM tile job at a time for the systolic array.
- Pops a job from the memory-mapped config FIFOs (tile addresses, strides, sizes, control bits).
- Fetches A and B operand rows over a single shared memory port and streams them into the array.
- Starts the compute and waits for completion, then optionally writes C back to memory before taking the next job.

Parameters:
ADDR_W, 32, width of memory addresses, base addresses and strides
DATA_W, 32, width of memory data and array row data
CNT_W, 10, width of the store word counter (must hold 31*31)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
conf_empty  in  1  config FIFOs empty; head entry valid when 0
read_all_buffers  out  1  one-cycle pop of all config FIFOs
tile_A_addr, tile_B_addr, tile_C_addr  in  ADDR_W  base byte addresses (FIFO head)
tile_A_stride, tile_B_stride  in  ADDR_W  byte stride between successive A / B rows
ksize, msize, nsize  in  5 each  tile dimensions, legal range 1..31
store, overwrite  in  1 each  GEMM control bits
mem_req  out  1  memory request; held until mem_gnt
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
sa_data  out  DATA_W  row data to array
sa_a_valid, sa_b_valid  out  1 each  one-cycle strobes: sa_data is an A / B row
sa_overwrite  out  1  latched overwrite bit; constant for the whole job
sa_start  out  1  one-cycle compute start
sa_done  in  1  compute complete
sa_c_rd  out  1  pop one C word from the array
sa_c_data  in  DATA_W  head C word
busy  out  1  high in every state except IDLE
done  out  1  one-cycle job-complete pulse
perf_cycles  out  32  busy-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=0): asynchronous. State goes to IDLE; all counters and latched registers clear; every output is 0. Applies mid-job: mem_req drops immediately and the outstanding job is abandoned.
- States: IDLE, FETCH_REQ, FETCH_WAIT, COMPUTE, STORE_REQ, FINISH.
- IDLE, conf_empty=0:
  - Latch all config inputs; pulse read_all_buffers in the same cycle.
  - A_ptr=tile_A_addr, B_ptr=tile_B_addr, k=0, sel=A.
  - If any latched size is 0: go to FINISH, no memory traffic. Otherwise go to FETCH_REQ.
- FETCH_REQ:
  - mem_req=1, mem_we=0, mem_addr = sel==A ? A_ptr : B_ptr. Address, we and data stay stable while waiting.
  - On mem_gnt go to FETCH_WAIT.
- FETCH_WAIT: exactly one read outstanding. On mem_rvalid:
  - sa_data=mem_rdata (registered; strobe and data appear one cycle after rvalid).
  - Pulse sa_a_valid or sa_b_valid according to sel.
  - If sel=A: A_ptr += tile_A_stride, sel=B, back to FETCH_REQ.
  - If sel=B: B_ptr += tile_B_stride, k++, sel=A. If k reaches ksize go to COMPUTE, else back to FETCH_REQ.
- Fetch order is A0,B0,A1,B1,... so there are 2*ksize reads per job.
- Pointer arithmetic is modulo 2^ADDR_W (wrap, no error).
- mem_rvalid outside FETCH_WAIT is ignored.
- COMPUTE:
  - sa_start pulses in the first cycle of the state.
  - sa_done is sampled only from the following cycle.
  - On sa_done: go to STORE_REQ if store=1, else FINISH.
- STORE_REQ:
  - mem_req=1, mem_we=1, mem_addr = tile_C_addr + 4*i, mem_wdata=sa_c_data.
  - On mem_gnt: pulse sa_c_rd in the same cycle, i++.
  - After msize*nsize grants go to FINISH. i uses CNT_W bits.
- FINISH: done=1 for one cycle, then IDLE. The next job may start the following cycle.
- sa_overwrite equals the latched overwrite bit from latch until the job returns to IDLE; 0 in IDLE.
- A config write to the FIFOs during a job has no effect until the scheduler returns to IDLE.

Optional Feature:
GEMM_PERF_CNT_EN
- Defined: perf_cycles increments every cycle busy=1 and saturates at 32'hFFFF_FFFF. It is cleared only by reset.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Single job, k=m=n=2, A=0x1000, strideA=0x10, B=0x2000, strideB=0x20, store=1, mem_gnt always 1, rvalid 2 cycles after grant -> reads at 0x1000, 0x2000, 0x1010, 0x2020; strobes A,B,A,B; one sa_start; after sa_done, writes at C, C+4, C+8, C+C; 4 sa_c_rd pulses; one done pulse; read_all_buffers pulsed exactly once.
- store=0, k=m=n=3 -> 6 reads, no mem_we=1 cycle, done pulses 1 cycle after sa_done.
- ksize=0 -> read_all_buffers and done pulse with no mem_req and no sa_start.
- mem_gnt held low 5 cycles during a fetch -> mem_req and mem_addr held constant for all 5 cycles; no strobe before rvalid.
- Two back-to-back jobs queued -> second read_all_buffers occurs 1 cycle after the first done; second job's latched overwrite appears on sa_overwrite.
- rst asserted in STORE_REQ -> mem_req, busy and sa_c_rd are 0 immediately; next job restarts cleanly. With GEMM_PERF_CNT_EN defined, perf_cycles equals the busy cycle count of the first test.

Source files
------------

// File: rtl/gemm_tile_scheduler.sv
// GEMM tile job sequencer: config pop, A/B row fetch, compute handshake, C store.
// Optional busy-cycle counter enabled with `define GEMM_PERF_CNT_EN.
module gemm_tile_scheduler #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conf_empty,
    output logic              read_all_buffers,
    input  logic [ADDR_W-1:0] tile_A_addr,
    input  logic [ADDR_W-1:0] tile_B_addr,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_A_stride,
    input  logic [ADDR_W-1:0] tile_B_stride,
    input  logic [4:0]        ksize,
    input  logic [4:0]        msize,
    input  logic [4:0]        nsize,
    input  logic              store,
    input  logic              overwrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sa_data,
    output logic              sa_a_valid,
    output logic              sa_b_valid,
    output logic              sa_overwrite,
    output logic              sa_start,
    input  logic              sa_done,
    output logic              sa_c_rd,
    input  logic [DATA_W-1:0] sa_c_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        COMPUTE,
        STORE_REQ,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] a_ptr, b_ptr, c_base;
    logic [ADDR_W-1:0] a_stride, b_stride;
    logic [4:0]        k_cnt, k_size, m_size, n_size;
    logic              sel_b;
    logic              store_q, ovw_q;
    logic              started;
    logic [CNT_W-1:0]  st_idx, st_total;
    logic [DATA_W-1:0] sa_data_q;
    logic              a_v_q, b_v_q;

    logic size_zero, k_last, st_last;

    assign size_zero = (ksize == 5'd0) || (msize == 5'd0) || (nsize == 5'd0);
    assign k_last    = (k_cnt + 5'd1) == k_size;
    assign st_total  = CNT_W'(m_size) * CNT_W'(n_size);
    assign st_last   = (st_idx + CNT_W'(1)) == st_total;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        read_all_buffers = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        sa_start         = 1'b0;
        sa_c_rd          = 1'b0;
        done             = 1'b0;
        unique case (state)
            IDLE: begin
                // rst term keeps the pop strobe low while reset is held
                if (!conf_empty) begin
                    read_all_buffers = rst;
                    state_nxt = size_zero ? FINISH : FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                mem_req  = 1'b1;
                mem_addr = sel_b ? b_ptr : a_ptr;
                if (mem_gnt) state_nxt = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = (sel_b && k_last) ? COMPUTE : FETCH_REQ;
                end
            end
            COMPUTE: begin
                sa_start = !started;
                if (started && sa_done) begin
                    state_nxt = store_q ? STORE_REQ : FINISH;
                end
            end
            STORE_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = c_base + ADDR_W'({st_idx, 2'b00});
                mem_wdata = sa_c_data;
                if (mem_gnt) begin
                    sa_c_rd = 1'b1;
                    if (st_last) state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_ptr     <= '0;
            b_ptr     <= '0;
            c_base    <= '0;
            a_stride  <= '0;
            b_stride  <= '0;
            k_cnt     <= '0;
            k_size    <= '0;
            m_size    <= '0;
            n_size    <= '0;
            sel_b     <= 1'b0;
            store_q   <= 1'b0;
            ovw_q     <= 1'b0;
            started   <= 1'b0;
            st_idx    <= '0;
            sa_data_q <= '0;
            a_v_q     <= 1'b0;
            b_v_q     <= 1'b0;
        end else begin
            a_v_q <= 1'b0;
            b_v_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!conf_empty) begin
                        a_ptr    <= tile_A_addr;
                        b_ptr    <= tile_B_addr;
                        c_base   <= tile_C_addr;
                        a_stride <= tile_A_stride;
                        b_stride <= tile_B_stride;
                        k_size   <= ksize;
                        m_size   <= msize;
                        n_size   <= nsize;
                        store_q  <= store;
                        ovw_q    <= overwrite;
                        k_cnt    <= '0;
                        sel_b    <= 1'b0;
                        st_idx   <= '0;
                        started  <= 1'b0;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_rvalid) begin
                        sa_data_q <= mem_rdata;
                        if (sel_b) begin
                            b_v_q <= 1'b1;
                            b_ptr <= b_ptr + b_stride;
                            k_cnt <= k_cnt + 5'd1;
                            sel_b <= 1'b0;
                        end else begin
                            a_v_q <= 1'b1;
                            a_ptr <= a_ptr + a_stride;
                            sel_b <= 1'b1;
                        end
                    end
                end
                COMPUTE: started <= 1'b1;
                STORE_REQ: begin
                    if (mem_gnt) st_idx <= st_idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign sa_data      = sa_data_q;
    assign sa_a_valid   = a_v_q;
    assign sa_b_valid   = b_v_q;
    assign busy         = (state != IDLE);
    assign sa_overwrite = ovw_q && (state != IDLE);

`ifdef GEMM_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed self-checking bench for gemm_tile_scheduler.
// Memory and array responders model grant/rvalid and sa_done latency.
module tb_gemm_tile_scheduler;

    logic        clk;
    logic        rst;
    logic        conf_empty;
    logic        read_all_buffers;
    logic [31:0] tile_A_addr, tile_B_addr, tile_C_addr;
    logic [31:0] tile_A_stride, tile_B_stride;
    logic [4:0]  ksize, msize, nsize;
    logic        store, overwrite;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] sa_data;
    logic        sa_a_valid, sa_b_valid, sa_overwrite, sa_start;
    logic        sa_done, sa_c_rd;
    logic [31:0] sa_c_data;
    logic        busy, done;
    logic [31:0] perf_cycles;

    gemm_tile_scheduler #(.ADDR_W(32), .DATA_W(32), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .conf_empty(conf_empty),
        .read_all_buffers(read_all_buffers),
        .tile_A_addr(tile_A_addr), .tile_B_addr(tile_B_addr),
        .tile_C_addr(tile_C_addr), .tile_A_stride(tile_A_stride),
        .tile_B_stride(tile_B_stride), .ksize(ksize), .msize(msize),
        .nsize(nsize), .store(store), .overwrite(overwrite),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .sa_data(sa_data), .sa_a_valid(sa_a_valid),
        .sa_b_valid(sa_b_valid), .sa_overwrite(sa_overwrite),
        .sa_start(sa_start), .sa_done(sa_done), .sa_c_rd(sa_c_rd),
        .sa_c_data(sa_c_data), .busy(busy), .done(done),
        .perf_cycles(perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0;
    int req_cnt, we_cnt, start_cnt, done_cnt, rab_cnt, crd_cnt, busy_cnt;
    int sadone_cyc;
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] sdat_q[$];
    logic        strb_q[$];
    logic        ovw_rec_q[$];
    int          done_cyc_q[$];
    int          rab_cyc_q[$];

    int          rv_cnt = 0;
    int          dn_cnt = 0;
    logic [31:0] rd_addr_hold = '0;

    // Monitor plus memory / array responders, all on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end else begin
                rd_addr_q.push_back(mem_addr);
            end
        end
        if (mem_req) req_cnt++;
        if (mem_we) we_cnt++;
        if (sa_a_valid) begin
            strb_q.push_back(1'b0);
            sdat_q.push_back(sa_data);
        end
        if (sa_b_valid) begin
            strb_q.push_back(1'b1);
            sdat_q.push_back(sa_data);
        end
        if (sa_start) begin
            start_cnt++;
            ovw_rec_q.push_back(sa_overwrite);
        end
        if (done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
        end
        if (read_all_buffers) begin
            rab_cnt++;
            rab_cyc_q.push_back(cyc);
        end
        if (sa_c_rd) crd_cnt++;
        if (busy) busy_cnt++;
        sa_c_data = 32'hC0DE_0000 + 32'(crd_cnt);

        mem_rvalid = 1'b0;
        if (!rst) begin
            rv_cnt = 0;
        end else if (rv_cnt != 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_addr_hold ^ 32'hA5A5_0000;
            end
        end
        if (mem_req && mem_gnt && !mem_we) begin
            rv_cnt = 2;
            rd_addr_hold = mem_addr;
        end

        sa_done = 1'b0;
        if (dn_cnt != 0) begin
            dn_cnt--;
            if (dn_cnt == 0) begin
                sa_done = 1'b1;
                sadone_cyc = cyc;
            end
        end
        if (sa_start) dn_cnt = 3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        req_cnt = 0; we_cnt = 0; start_cnt = 0; done_cnt = 0;
        rab_cnt = 0; crd_cnt = 0; busy_cnt = 0; sadone_cyc = 0;
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        sdat_q.delete(); strb_q.delete(); ovw_rec_q.delete();
        done_cyc_q.delete(); rab_cyc_q.delete();
        sa_c_data = 32'hC0DE_0000;
    endtask

    task automatic set_job(input logic [31:0] a, input logic [31:0] sa,
                           input logic [31:0] b, input logic [31:0] sb,
                           input logic [31:0] c, input logic [4:0] k,
                           input logic [4:0] m, input logic [4:0] n,
                           input logic st, input logic ow);
        tile_A_addr = a; tile_A_stride = sa;
        tile_B_addr = b; tile_B_stride = sb;
        tile_C_addr = c;
        ksize = k; msize = m; nsize = n;
        store = st; overwrite = ow;
    endtask

    task automatic wait_done(input int n, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= n) break;
            tick();
        end
        n_chk++;
        if (done_cnt < n) begin
            n_fail++;
            $display("FAIL %s timeout: done count %0d, required %0d", nm, done_cnt, n);
        end
    endtask

    task automatic test_reset();
        conf_empty = 1'b0;
        @(negedge clk);
        #1;
        n_chk++;
        if ({read_all_buffers, mem_req, mem_we, busy, done, sa_start,
             sa_a_valid, sa_b_valid, sa_c_rd, sa_overwrite} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 0", {read_all_buffers, mem_req,
                     mem_we, busy, done, sa_start, sa_a_valid, sa_b_valid, sa_c_rd, sa_overwrite});
        end
        n_chk++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem: addr %h wdata %h, required 0", mem_addr, mem_wdata);
        end
        n_chk++;
        if (sa_data !== 32'h0 || perf_cycles !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: sa_data %h perf %h, required 0", sa_data, perf_cycles);
        end
        conf_empty = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b, required 0", busy);
        end
    endtask

    task automatic test_single_job();
        logic [31:0] exp_rd [4] = '{32'h1000, 32'h2000, 32'h1010, 32'h2020};
        logic        exp_sel[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tick();
        clear_log();
        set_job(32'h1000, 32'h10, 32'h2000, 32'h20, 32'h3000, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0);
        conf_empty = 1'b0;
        tick();
        conf_empty = 1'b1;
        wait_done(1, 200, "single");
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rd_addr_q.size() <= i || rd_addr_q[i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL single_rd%0d: got %h, required %h", i,
                         (rd_addr_q.size() > i) ? rd_addr_q[i] : 32'hx, exp_rd[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (strb_q.size() <= i || strb_q[i] !== exp_sel[i] ||
                sdat_q[i] !== (exp_rd[i] ^ 32'hA5A5_0000)) begin
                n_fail++;
                $display("FAIL single_strobe%0d: got sel/data %b/%h, required %b/%h", i,
                         (strb_q.size() > i) ? strb_q[i] : 1'bx,
                         (sdat_q.size() > i) ? sdat_q[i] : 32'hx,
                         exp_sel[i], exp_rd[i] ^ 32'hA5A5_0000);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (wr_addr_q.size() <= i || wr_addr_q[i] !== 32'h3000 + 32'(4 * i) ||
                wr_data_q[i] !== 32'hC0DE_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL single_wr%0d: got addr/data %h/%h, required %h/%h", i,
                         (wr_addr_q.size() > i) ? wr_addr_q[i] : 32'hx,
                         (wr_data_q.size() > i) ? wr_data_q[i] : 32'hx,
                         32'h3000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            end
        end
        n_chk++;
        if (start_cnt != 1 || crd_cnt != 4 || done_cnt != 1 || rab_cnt != 1) begin
            n_fail++;
            $display("FAIL single_counts: start %0d crd %0d done %0d rab %0d, required 1 4 1 1",
                     start_cnt, crd_cnt, done_cnt, rab_cnt);
        end
        n_chk++;
        if (busy_cnt != 21) begin
            n_fail++;
            $display("FAIL single_busy: got %0d, required 21", busy_cnt);
        end
`ifdef GEMM_PERF_CNT_EN
        n_chk++;
        if (perf_cycles !== 32'd21) begin
            n_fail++;
            $display("FAIL single_perf: got %0d, required 21", perf_cycles);
        end
`else
        n_chk++;
        if (perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL single_perf: got %0d, required 0", perf_cycles);
        end
`endif
    endtask

    task automatic test_no_store();
        clear_log();
        set_job(32'h100, 32'h4, 32'h200, 32'h8, 32'h300, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0);
        conf_empty = 1'b0;
        tick();
        conf_empty = 1'b1;
        wait_done(1, 300, "no_store");
        tick();
        n_chk++;
        if (rd_addr_q.size() != 6 || rd_addr_q[5] !== 32'h210) begin
            n_fail++;
            $display("FAIL nostore_reads: got %0d reads, required 6 ending at 210",
                     rd_addr_q.size());
        end
        n_chk++;
        if (we_cnt != 0) begin
            n_fail++;
            $display("FAIL nostore_we: got %0d write cycles, required 0", we_cnt);
        end
        n_chk++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] - sadone_cyc != 1) begin
            n_fail++;
            $display("FAIL nostore_latency: done at %0d, sa_done at %0d, required +1",
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, sadone_cyc);
        end
    endtask

    task automatic test_zero_size();
        clear_log();
        set_job(32'h100, 32'h4, 32'h200, 32'h8, 32'h300, 5'd0, 5'd2, 5'd2, 1'b1, 1'b0);
        conf_empty = 1'b0;
        tick();
        conf_empty = 1'b1;
        wait_done(1, 20, "zero_size");
        tick();
        n_chk++;
        if (rab_cnt != 1 || done_cnt != 1 || req_cnt != 0 || start_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_size: rab %0d done %0d req %0d start %0d, required 1 1 0 0",
                     rab_cnt, done_cnt, req_cnt, start_cnt);
        end
    endtask

    task automatic test_gnt_stall();
        clear_log();
        mem_gnt = 1'b0;
        set_job(32'h4000, 32'h4, 32'h5000, 32'h4, 32'h6000, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
        conf_empty = 1'b0;
        tick();
        conf_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h4000 ||
                strb_q.size() != 0) begin
                n_fail++;
                $display("FAIL stall_c%0d: req %b we %b addr %h strobes %0d, required 1 0 4000 0",
                         i, mem_req, mem_we, mem_addr, strb_q.size());
            end
            tick();
        end
        mem_gnt = 1'b1;
        wait_done(1, 100, "stall");
        tick();
        n_chk++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 32'h4000 ||
            rd_addr_q[1] !== 32'h5000 || strb_q.size() != 2) begin
            n_fail++;
            $display("FAIL stall_reads: got %0d reads %0d strobes, required 2 2",
                     rd_addr_q.size(), strb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic sw = 1'b0;
        clear_log();
        set_job(32'h6000, 32'h4, 32'h7000, 32'h4, 32'h8000, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0);
        conf_empty = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rab_cnt == 1 && !sw) begin
                set_job(32'h9000, 32'h4, 32'hA000, 32'h4, 32'hB000,
                        5'd1, 5'd1, 5'd1, 1'b0, 1'b1);
                sw = 1'b1;
            end
            if (rab_cnt >= 2) conf_empty = 1'b1;
            if (done_cnt >= 2) break;
        end
        conf_empty = 1'b1;
        tick();
        n_chk++;
        if (rab_cnt != 2 || done_cnt != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: rab %0d done %0d, required 2 2", rab_cnt, done_cnt);
        end
        n_chk++;
        if (rab_cyc_q.size() != 2 || done_cyc_q.size() < 1 ||
            rab_cyc_q[1] - done_cyc_q[0] != 1) begin
            n_fail++;
            $display("FAIL b2b_gap: second pop at %0d, first done at %0d, required +1",
                     (rab_cyc_q.size() > 1) ? rab_cyc_q[1] : -1,
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
        end
        n_chk++;
        if (ovw_rec_q.size() != 2 || ovw_rec_q[0] !== 1'b0 || ovw_rec_q[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overwrite: got %0d entries, required 0 then 1", ovw_rec_q.size());
        end
        n_chk++;
        if (rd_addr_q.size() != 4 || rd_addr_q[2] !== 32'h9000 || wr_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL b2b_traffic: reads %0d writes %0d, required 4 1",
                     rd_addr_q.size(), wr_addr_q.size());
        end
    endtask

    task automatic test_reset_in_store();
        int seen = 0;
        clear_log();
        set_job(32'h100, 32'h4, 32'h200, 32'h4, 32'hB000, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0);
        conf_empty = 1'b0;
        tick();
        conf_empty = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mem_we === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_chk++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL rst_store_reach: store phase not seen, required within 100 cycles");
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || sa_c_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_store_outputs: req %b busy %b c_rd %b, required 0 0 0",
                     mem_req, busy, sa_c_rd);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        clear_log();
        set_job(32'hC000, 32'h4, 32'hD000, 32'h4, 32'hE000, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0);
        conf_empty = 1'b0;
        tick();
        conf_empty = 1'b1;
        wait_done(1, 100, "restart");
        tick();
        n_chk++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 32'hC000 || rd_addr_q[1] !== 32'hD000 ||
            wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'hE000) begin
            n_fail++;
            $display("FAIL restart_traffic: reads %0d writes %0d, required 2 1 at C000/D000/E000",
                     rd_addr_q.size(), wr_addr_q.size());
        end
        n_chk++;
        if (busy_cnt != 12) begin
            n_fail++;
            $display("FAIL restart_busy: got %0d, required 12", busy_cnt);
        end
`ifdef GEMM_PERF_CNT_EN
        n_chk++;
        if (perf_cycles !== 32'd12) begin
            n_fail++;
            $display("FAIL restart_perf: got %0d, required 12", perf_cycles);
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        conf_empty = 1'b1;
        mem_gnt = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        sa_done = 1'b0;
        sa_c_data = 32'hC0DE_0000;
        set_job('0, '0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        clear_log();
        tick();
        tick();
        test_reset();
        test_single_job();
        test_no_store();
        test_zero_size();
        test_gnt_stall();
        test_back_to_back();
        test_reset_in_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
